operand2_shifter_pipe: RTL and testbench

- Parametrised, pipelined successor to the EX-stage second-operand generator.
- Produces Val2 and the ARM shifter carry-out for all data-processing and LDR/STR operand forms.
- Adds register-specified shift amounts (Rs[7:0]), RRX, carry-out generation, a valid/ready handshake, a flush input and configurable pipeline depth.
- Sits between ID/EX register outputs and the ALU; backpressure comes from the ALU/EX stall logic.

---
 rtl/operand2_shifter_pipe_pkg.sv | 40 ++++
 rtl/operand2_shifter_pipe_barrel.sv | 74 +++++++
 rtl/operand2_shifter_pipe.sv | 172 +++++++++++++++++
 tb/tb_operand2_shifter_pipe.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand2_shifter_pipe_pkg.sv
// ============================================================================
// operand2_pkg: shift kinds, operand modes and amount normalisation helper
// Rev 1.0
// ============================================================================
`default_nettype none

package operand2_pkg;

   localparam logic [1:0] SH_LSL = 2'd0;
   localparam logic [1:0] SH_LSR = 2'd1;
   localparam logic [1:0] SH_ASR = 2'd2;
   localparam logic [1:0] SH_ROR = 2'd3;

   typedef enum logic [1:0] {
      MODE_MEM,
      MODE_IMM,
      MODE_REGSH,
      MODE_IMMSH
   } mode_t;

   // Immediate LSR/ASR #0 mean a full-width shift; ROR #0 (RRX) is flagged
   // separately by the caller and leaves the amount at zero.
   function automatic logic [8:0] normalise_amount(
      input logic [1:0] kind,
      input logic       reg_shift,
      input logic [7:0] rs,
      input logic [4:0] shift_imm,
      input logic [8:0] width9
   );
      if (reg_shift)
         return {1'b0, rs};
      else if ((shift_imm == 5'd0) && ((kind == SH_LSR) || (kind == SH_ASR)))
         return width9;
      else
         return {4'd0, shift_imm};
   endfunction

endpackage

`default_nettype wire

// File: rtl/operand2_shifter_pipe_barrel.sv
// ============================================================================
// operand2_barrel: combinational ARM shifter producing value and carry-out
// Rev 1.0
// ============================================================================
`default_nettype none

module operand2_barrel
   import operand2_pkg::*;
#(
   parameter int W   = 32,
   parameter int SHW = $clog2(W)
) (
   input  logic [1:0]   kind,
   input  logic [8:0]   amount,
   input  logic         rrx,
   input  logic         carry_in,
   input  logic [W-1:0] value,
   output logic [W-1:0] result,
   output logic         carry
);

   localparam logic [8:0]   W9  = 9'(W);
   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [8:0]   amt_m1;
   logic [8:0]   rot_amt;
   logic [W-1:0] shl;
   logic [W-1:0] shr;
   logic [W-1:0] asr;
   logic [W-1:0] rot;
   logic         lsl_c;
   logic         low_c;

   assign amt_m1  = amount - 9'd1;
   assign rot_amt = {{(9-SHW){1'b0}}, amount[SHW-1:0]};
   assign shl     = value << amount;
   assign shr     = value >> amount;
   assign asr     = $signed(value) >>> amount;
   // A zero rotate makes the left term shift by W and vanish, so rot == value.
   assign rot     = (value >> rot_amt) | (value << (W9 - rot_amt));
   assign lsl_c   = |(value & (ONE << (W9 - amount)));
   assign low_c   = |(value & (ONE << amt_m1));

   always_comb begin
      result = value;
      carry  = carry_in;
      if (rrx) begin
         result = {carry_in, value[W-1:1]};
         carry  = value[0];
      end else if (amount != 9'd0) begin
         case (kind)
            SH_LSL: begin
               result = (amount < W9) ? shl : '0;
               carry  = (amount < W9) ? lsl_c : ((amount == W9) ? value[0] : 1'b0);
            end
            SH_LSR: begin
               result = (amount < W9) ? shr : '0;
               carry  = (amount < W9) ? low_c : ((amount == W9) ? value[W-1] : 1'b0);
            end
            SH_ASR: begin
               result = (amount < W9) ? asr : {W{value[W-1]}};
               carry  = (amount < W9) ? low_c : value[W-1];
            end
            default: begin
               result = rot;
               carry  = rot[W-1];
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/operand2_shifter_pipe.sv
// ============================================================================
// operand2_shifter_pipe: pipelined Val2 / shifter-carry generator with handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module operand2_shifter_pipe
   import operand2_pkg::*;
#(
   parameter  int W      = 32,
   parameter  int STAGES = 1,
   localparam int SHW    = $clog2(W)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] val_rm,
   input  logic [7:0]   val_rs,
   input  logic [11:0]  shift_operand,
   input  logic         imm,
   input  logic         mem_rw,
   input  logic         carry_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] val2,
   output logic         carry_out
);

   localparam logic [8:0] W9 = 9'(W);

   mode_t        mode;
   logic [W-1:0] d_value;
   logic [1:0]   d_kind;
   logic [8:0]   d_amt;
   logic         d_rrx;

   logic [W-1:0] b_value;
   logic [1:0]   b_kind;
   logic [8:0]   b_amt;
   logic         b_rrx;
   logic         b_cin;
   logic [W-1:0] b_result;
   logic         b_carry;

   logic         feed_valid;
   logic         adv_out;

   always_comb begin
      if (mem_rw)
         mode = MODE_MEM;
      else if (imm)
         mode = MODE_IMM;
      else if (shift_operand[4])
         mode = MODE_REGSH;
      else
         mode = MODE_IMMSH;
   end

   // Memory and rotated-immediate forms reuse the barrel: LSL #0 and ROR #2r.
   always_comb begin
      d_value = val_rm;
      d_kind  = shift_operand[6:5];
      d_amt   = 9'd0;
      d_rrx   = 1'b0;
      case (mode)
         MODE_MEM: begin
            d_value = {{(W-12){1'b0}}, shift_operand};
            d_kind  = SH_LSL;
         end
         MODE_IMM: begin
            d_value = {{(W-8){1'b0}}, shift_operand[7:0]};
            d_kind  = SH_ROR;
            d_amt   = {4'd0, shift_operand[11:8], 1'b0};
         end
         MODE_REGSH: begin
            d_amt = normalise_amount(shift_operand[6:5], 1'b1, val_rs,
                                     shift_operand[11:7], W9);
         end
         default: begin
            d_amt = normalise_amount(shift_operand[6:5], 1'b0, val_rs,
                                     shift_operand[11:7], W9);
            d_rrx = (shift_operand[6:5] == SH_ROR) && (shift_operand[11:7] == 5'd0);
         end
      endcase
   end

   assign adv_out = !out_valid || out_ready;

   generate
      if (STAGES == 1) begin : g_single
         assign b_value    = d_value;
         assign b_kind     = d_kind;
         assign b_amt      = d_amt;
         assign b_rrx      = d_rrx;
         assign b_cin      = carry_in;
         assign feed_valid = in_valid;
         assign in_ready   = adv_out;
      end else begin : g_double
         logic         s1_valid;
         logic [W-1:0] s1_value;
         logic [1:0]   s1_kind;
         logic [8:0]   s1_amt;
         logic         s1_rrx;
         logic         s1_cin;

         assign in_ready = !s1_valid || adv_out;

         always_ff @(posedge clk) begin
            if (rst) begin
               s1_valid <= 1'b0;
               s1_value <= '0;
               s1_kind  <= SH_LSL;
               s1_amt   <= 9'd0;
               s1_rrx   <= 1'b0;
               s1_cin   <= 1'b0;
            end else if (flush) begin
               s1_valid <= 1'b0;
            end else if (in_ready) begin
               s1_valid <= in_valid;
               if (in_valid) begin
                  s1_value <= d_value;
                  s1_kind  <= d_kind;
                  s1_amt   <= d_amt;
                  s1_rrx   <= d_rrx;
                  s1_cin   <= carry_in;
               end
            end
         end

         assign b_value    = s1_value;
         assign b_kind     = s1_kind;
         assign b_amt      = s1_amt;
         assign b_rrx      = s1_rrx;
         assign b_cin      = s1_cin;
         assign feed_valid = s1_valid;
      end
   endgenerate

   operand2_barrel #(
      .W   (W),
      .SHW (SHW)
   ) u_barrel (
      .kind     (b_kind),
      .amount   (b_amt),
      .rrx      (b_rrx),
      .carry_in (b_cin),
      .value    (b_value),
      .result   (b_result),
      .carry    (b_carry)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         val2      <= '0;
         carry_out <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (adv_out) begin
         out_valid <= feed_valid;
         if (feed_valid) begin
            val2      <= b_result;
            carry_out <= b_carry;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_operand2_shifter_pipe.sv
// ============================================================================
// tb_operand2_shifter_pipe: directed bench for single- and two-stage shifters
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_operand2_shifter_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   logic        a_flush = 0, a_in_valid = 0, a_in_ready, a_imm = 0, a_mem_rw = 0, a_carry_in = 0;
   logic        a_out_valid, a_out_ready = 1, a_carry_out;
   logic [31:0] a_val_rm = 0, a_val2;
   logic [7:0]  a_val_rs = 0;
   logic [11:0] a_shift_operand = 0;

   logic        b_flush = 0, b_in_valid = 0, b_in_ready, b_imm = 0, b_mem_rw = 0, b_carry_in = 0;
   logic        b_out_valid, b_out_ready = 1, b_carry_out;
   logic [31:0] b_val_rm = 0, b_val2;
   logic [7:0]  b_val_rs = 0;
   logic [11:0] b_shift_operand = 0;

   operand2_shifter_pipe #(.W(32), .STAGES(1)) u_dut1 (
      .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .val_rm(a_val_rm), .val_rs(a_val_rs), .shift_operand(a_shift_operand), .imm(a_imm),
      .mem_rw(a_mem_rw), .carry_in(a_carry_in), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .val2(a_val2), .carry_out(a_carry_out)
   );

   operand2_shifter_pipe #(.W(32), .STAGES(2)) u_dut2 (
      .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .val_rm(b_val_rm), .val_rs(b_val_rs), .shift_operand(b_shift_operand), .imm(b_imm),
      .mem_rw(b_mem_rw), .carry_in(b_carry_in), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .val2(b_val2), .carry_out(b_carry_out)
   );

   // One transfer into the single-stage instance; result is visible on return.
   task automatic send1(input logic [31:0] rm, input logic [7:0] rs, input logic [11:0] so,
                        input logic im, input logic mem, input logic cin);
      @(negedge clk);
      a_val_rm = rm; a_val_rs = rs; a_shift_operand = so;
      a_imm = im; a_mem_rw = mem; a_carry_in = cin; a_in_valid = 1'b1;
      @(posedge clk);
      #1;
      a_in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (a_out_valid !== 1'b0 || a_val2 !== 32'h0 || a_carry_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_s1 valid=%b val2=%h c=%b, want 0/0/0", a_out_valid, a_val2, a_carry_out);
      end
      checks++;
      if (b_out_valid !== 1'b0 || b_val2 !== 32'h0 || b_carry_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_s2 valid=%b val2=%h c=%b, want 0/0/0", b_out_valid, b_val2, b_carry_out);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %b%b, want 11", a_in_ready, b_in_ready);
      end
   endtask

   task automatic test_imm();
      logic [11:0] so_t [4] = '{12'h2FF, 12'h4FF, 12'h0AB, 12'h0AB};
      logic        ci_t [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [31:0] ev_t [4] = '{32'hF000000F, 32'hFF000000, 32'h000000AB, 32'h000000AB};
      logic        ec_t [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         send1(32'hDEADBEEF, 8'h00, so_t[i], 1'b1, 1'b0, ci_t[i]);
         checks++;
         if (a_out_valid !== 1'b1 || a_val2 !== ev_t[i] || a_carry_out !== ec_t[i]) begin
            errors++;
            $display("FAIL imm[%0d] valid=%b val2=%h c=%b, want 1 %h %b",
                     i, a_out_valid, a_val2, a_carry_out, ev_t[i], ec_t[i]);
         end
      end
   endtask

   task automatic test_reg_shift();
      logic [31:0] rm_t [8] = '{32'h80000001, 32'h80000001, 32'h80000001, 32'h80000001,
                                32'h0000000F, 32'h7FFFFFFF, 32'h00000001, 32'h00000001};
      logic [7:0]  rs_t [8] = '{8'd32, 8'd33, 8'd0, 8'd1, 8'd36, 8'd32, 8'd32, 8'd1};
      logic [11:0] so_t [8] = '{12'h030, 12'h030, 12'h030, 12'h030,
                                12'h070, 12'h070, 12'h010, 12'h090};
      logic        ci_t [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] ev_t [8] = '{32'h0, 32'h0, 32'h80000001, 32'h40000000,
                                32'hF0000000, 32'h7FFFFFFF, 32'h0, 32'h00000002};
      logic        ec_t [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 8; i++) begin
         send1(rm_t[i], rs_t[i], so_t[i], 1'b0, 1'b0, ci_t[i]);
         checks++;
         if (a_out_valid !== 1'b1 || a_val2 !== ev_t[i] || a_carry_out !== ec_t[i]) begin
            errors++;
            $display("FAIL reg_shift[%0d] valid=%b val2=%h c=%b, want 1 %h %b",
                     i, a_out_valid, a_val2, a_carry_out, ev_t[i], ec_t[i]);
         end
      end
   endtask

   task automatic test_imm_shift();
      logic [31:0] rm_t [6] = '{32'h00000003, 32'h80000000, 32'hF000000F,
                                32'h12345678, 32'h80000003, 32'h80000000};
      logic [11:0] so_t [6] = '{12'h060, 12'h040, 12'h200, 12'h000, 12'h0C0, 12'h020};
      logic        ci_t [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [31:0] ev_t [6] = '{32'h80000001, 32'hFFFFFFFF, 32'h000000F0,
                                32'h12345678, 32'hC0000001, 32'h00000000};
      logic        ec_t [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 6; i++) begin
         send1(rm_t[i], 8'hFF, so_t[i], 1'b0, 1'b0, ci_t[i]);
         checks++;
         if (a_out_valid !== 1'b1 || a_val2 !== ev_t[i] || a_carry_out !== ec_t[i]) begin
            errors++;
            $display("FAIL imm_shift[%0d] valid=%b val2=%h c=%b, want 1 %h %b",
                     i, a_out_valid, a_val2, a_carry_out, ev_t[i], ec_t[i]);
         end
      end
   endtask

   task automatic test_mem();
      for (int i = 0; i < 2; i++) begin
         send1(32'hFFFFFFFF, 8'h05, 12'hABC, 1'b1, 1'b1, i[0]);
         checks++;
         if (a_out_valid !== 1'b1 || a_val2 !== 32'h00000ABC || a_carry_out !== i[0]) begin
            errors++;
            $display("FAIL mem[%0d] valid=%b val2=%h c=%b, want 1 00000abc %b",
                     i, a_out_valid, a_val2, a_carry_out, i[0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rm_q [8];
      logic [31:0] held;
      logic        stalled, hs_in, hs_out;
      int          sent, got;
      for (int i = 0; i < 8; i++) rm_q[i] = {i[0], 31'(i * 3 + 1)};
      sent = 0; got = 0; stalled = 1'b0; held = '0;
      b_shift_operand = 12'h080; b_val_rs = 8'h00; b_imm = 1'b0; b_mem_rw = 1'b0; b_carry_in = 1'b0;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         @(negedge clk);
         b_out_ready = !(cyc >= 3 && cyc <= 5);
         b_in_valid  = (sent < 8);
         if (sent < 8) b_val_rm = rm_q[sent];
         #1;
         hs_in  = b_in_valid && b_in_ready;
         hs_out = b_out_valid && b_out_ready;
         if (cyc == 4) begin
            checks++;
            if (b_in_ready !== 1'b0) begin
               errors++;
               $display("FAIL b2b_full_ready in_ready=%b, want 0", b_in_ready);
            end
         end
         if (b_out_valid && !b_out_ready) begin
            if (stalled) begin
               checks++;
               if (b_val2 !== held) begin
                  errors++;
                  $display("FAIL b2b_stall_hold val2=%h, want %h", b_val2, held);
               end
            end
            held = b_val2;
            stalled = 1'b1;
         end else begin
            stalled = 1'b0;
         end
         if (hs_out) begin
            checks++;
            if (got >= 8) begin
               errors++;
               $display("FAIL b2b_extra output val2=%h, want none", b_val2);
            end else if (b_val2 !== {rm_q[got][30:0], 1'b0} || b_carry_out !== rm_q[got][31]) begin
               errors++;
               $display("FAIL b2b_data[%0d] val2=%h c=%b, want %h %b", got, b_val2, b_carry_out,
                        {rm_q[got][30:0], 1'b0}, rm_q[got][31]);
            end
            got++;
         end
         @(posedge clk);
         if (hs_in) sent++;
      end
      b_in_valid = 1'b0;
      b_out_ready = 1'b1;
      checks++;
      if (got != 8 || sent != 8) begin
         errors++;
         $display("FAIL b2b_count got=%0d sent=%0d, want 8 8", got, sent);
      end
      repeat (3) begin
         @(posedge clk);
         #1;
         checks++;
         if (b_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_dup out_valid=%b, want 0", b_out_valid);
         end
      end
   endtask

   task automatic test_flush();
      // Single-stage, empty pipe: flush must override an accepted input.
      @(negedge clk);
      a_in_valid = 1'b1; a_flush = 1'b1; a_mem_rw = 1'b1; a_shift_operand = 12'h123;
      @(posedge clk);
      #1;
      a_in_valid = 1'b0; a_flush = 1'b0; a_mem_rw = 1'b0;
      checks++;
      if (a_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_s1 out_valid=%b, want 0", a_out_valid);
      end
      // Two-stage with two items held, third offered on the flush cycle.
      b_out_ready = 1'b0; b_shift_operand = 12'h000; b_carry_in = 1'b0;
      @(negedge clk); b_in_valid = 1'b1; b_val_rm = 32'hAAAA0001;
      @(posedge clk);
      @(negedge clk); b_val_rm = 32'hAAAA0002;
      @(posedge clk);
      @(negedge clk);
      b_val_rm = 32'hAAAA0003; b_flush = 1'b1;
      #1;
      checks++;
      if (b_out_valid !== 1'b1 || b_in_ready !== 1'b0) begin
         errors++;
         $display("FAIL flush_prefill valid=%b in_ready=%b, want 1 0", b_out_valid, b_in_ready);
      end
      @(posedge clk);
      #1;
      b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
      checks++;
      if (b_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_s2 out_valid=%b, want 0", b_out_valid);
      end
      repeat (4) begin
         @(posedge clk);
         #1;
         checks++;
         if (b_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_ghost out_valid=%b val2=%h, want 0", b_out_valid, b_val2);
         end
      end
   endtask

   task automatic test_reset_mid();
      b_out_ready = 1'b0;
      @(negedge clk);
      b_in_valid = 1'b1; b_val_rm = 32'h00000003; b_shift_operand = 12'h060; b_carry_in = 1'b1;
      @(posedge clk);
      #1;
      b_val_rm = 32'h00000005;
      @(posedge clk);
      #1;
      checks++;
      if (b_out_valid !== 1'b1 || b_val2 !== 32'h80000001 || b_carry_out !== 1'b1) begin
         errors++;
         $display("FAIL rrx_s2 valid=%b val2=%h c=%b, want 1 80000001 1",
                  b_out_valid, b_val2, b_carry_out);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
      checks++;
      if (b_out_valid !== 1'b0 || b_val2 !== 32'h0 || b_carry_out !== 1'b0 || b_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid valid=%b val2=%h c=%b rdy=%b, want 0 0 0 1",
                  b_out_valid, b_val2, b_carry_out, b_in_ready);
      end
   endtask

   initial begin
      test_reset();
      test_imm();
      test_reg_shift();
      test_imm_shift();
      test_mem();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1);
   end

endmodule

`default_nettype wire
